// File: rtl/lfsr_word_packer.sv
// lfsr_word_packer: pulls bytes from an 8-bit LFSR core and packs four
// consecutive bytes, MSB-first, into 32-bit words. Words are queued in a
// small circular FIFO presented on a valid/ready stream port. A sticky
// flag reports a stuck generator (two consecutive taken bytes equal).

module lfsr_word_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     flush,
  input  logic                     clr_flag,
  input  logic [7:0]               lfsr_in,
  output logic                     lfsr_enable,
  output logic [31:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     stuck_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Operating mode of the packer; decoded every cycle from run, byte
  // position and FIFO space, so IDLE/STALL take effect without delay.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } mode_e;

  mode_e        mode_s;
  logic [1:0]   byte_idx_r;
  logic [31:0]  word_r;
  logic [7:0]   last_byte_r;
  logic         last_valid_r;
  logic         stuck_r;
  logic [31:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_nxt_s;
  logic         valid_r;
  logic         full_s;
  logic         pop_s;
  logic         take_s;
  logic         push_s;
  logic         detect_s;
  logic [31:0]  push_word_s;

  // FIFO status and handshake qualifiers
  always_comb begin
    full_s      = (level_r == LW'(DEPTH));
    pop_s       = valid_r & m_ready;
    push_word_s = {word_r[31:8], lfsr_in};
  end

  // Mode decode: run low idles; last lane with no room and no pop stalls
  always_comb begin
    mode_s = IDLE;
    if (!run) begin
      mode_s = IDLE;
    end else if ((byte_idx_r == 2'd3) && full_s && !pop_s) begin
      mode_s = STALL;
    end else begin
      mode_s = COLLECT;
    end
  end

  // Core enable and take/push qualifiers; reset and flush suppress a take
  always_comb begin
    take_s   = 1'b0;
    push_s   = 1'b0;
    detect_s = 1'b0;
    if ((mode_s == COLLECT) && !rst && !flush) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
    push_s   = take_s & (byte_idx_r == 2'd3);
    detect_s = take_s & last_valid_r & (lfsr_in == last_byte_r);
  end

  assign lfsr_enable = take_s;

  // Byte lane steering and partial-word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_r <= 2'd0;
      word_r     <= 32'd0;
    end else if (flush) begin
      byte_idx_r <= 2'd0;
      word_r     <= 32'd0;
    end else if (take_s) begin
      case (byte_idx_r)
        2'd0:    word_r[31:24] <= lfsr_in;
        2'd1:    word_r[23:16] <= lfsr_in;
        2'd2:    word_r[15:8]  <= lfsr_in;
        default: word_r        <= 32'd0;  // last lane: word leaves via push
      endcase
      byte_idx_r <= byte_idx_r + 2'd1;
    end
  end

  // Repeated-byte detection with sticky flag; a detect beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      last_byte_r  <= 8'd0;
      last_valid_r <= 1'b0;
      stuck_r      <= 1'b0;
    end else begin
      if (take_s) begin
        last_byte_r  <= lfsr_in;
        last_valid_r <= 1'b1;
      end
      if (detect_s) begin
        stuck_r <= 1'b1;
      end else if (clr_flag) begin
        stuck_r <= 1'b0;
      end
    end
  end

  // Next FIFO occupancy; simultaneous push and pop leave it unchanged
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Circular FIFO storage, pointers, occupancy and valid flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      valid_r  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_word_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != LW'(0));
    end
  end

  assign m_data     = mem_r[rd_ptr_r];
  assign m_valid    = valid_r;
  assign fifo_level = level_r;
  assign stuck_flag = stuck_r;

endmodule
